// File: rtl/decode_ctrl_if.sv
// Purpose: ID/EX handshake and EX payload bundle for decode_ctrl.
// slave  : the decode controller (consumes ID inputs, drives EX outputs).
// master : the surrounding pipeline / testbench (drives ID inputs, ex_ready, flush).
// Signals: id_valid, id_instr, id_ready, flush, ex_ready, ex_valid, ex_extop,
//          ex_imm16, ex_shamt, ex_rs, ex_rt, ex_memread, ctrl_state, stall_cnt.
interface decode_ctrl_if;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned IMM_W   = 16;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned EXT_W   = 2;
  localparam int unsigned ST_W    = 2;
  localparam int unsigned CNT_W   = 16;

  logic               id_valid;
  logic [INSTR_W-1:0] id_instr;
  logic               id_ready;
  logic               flush;
  logic               ex_ready;
  logic               ex_valid;
  logic [EXT_W-1:0]   ex_extop;
  logic [IMM_W-1:0]   ex_imm16;
  logic [REG_W-1:0]   ex_shamt;
  logic [REG_W-1:0]   ex_rs;
  logic [REG_W-1:0]   ex_rt;
  logic               ex_memread;
  logic [ST_W-1:0]    ctrl_state;
  logic [CNT_W-1:0]   stall_cnt;

  modport master (
    output id_valid, id_instr, flush, ex_ready,
    input  id_ready, ex_valid, ex_extop, ex_imm16, ex_shamt, ex_rs, ex_rt,
           ex_memread, ctrl_state, stall_cnt
  );

  modport slave (
    input  id_valid, id_instr, flush, ex_ready,
    output id_ready, ex_valid, ex_extop, ex_imm16, ex_shamt, ex_rs, ex_rt,
           ex_memread, ctrl_state, stall_cnt
  );
endinterface

// File: rtl/decode_ctrl.sv
// Purpose: ID-stage decode with a registered EX entry, load-use bubble
//          insertion, branch flush and EX back-pressure tracking.
// Ports  : clk, rst_n (async active-low), bus (decode_ctrl_if.slave).
// Option : DECODE_STALL_CNT_EN enables the saturating load-use bubble counter
//          on stall_cnt; when undefined stall_cnt is tied to 0.
module decode_ctrl (
  input logic         clk,
  input logic         rst_n,
  decode_ctrl_if.slave bus
);

  localparam int unsigned IMM_W = 16;
  localparam int unsigned REG_W = 5;
  localparam int unsigned OP_W  = 6;

  typedef enum logic [1:0] {
    ST_ISSUE    = 2'b00,
    ST_LU_STALL = 2'b01,
    ST_BP_STALL = 2'b10
  } state_e;

  typedef struct packed {
    logic             valid;
    logic [1:0]       extop;
    logic [IMM_W-1:0] imm16;
    logic [REG_W-1:0] shamt;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic             memread;
  } ex_entry_t;

  ex_entry_t ex_q, ex_d;
  state_e    state_q, state_d;

  // ID field extraction
  logic [OP_W-1:0]  opcode, funct;
  logic [REG_W-1:0] id_rs, id_rt;
  assign opcode = bus.id_instr[31:26];
  assign funct  = bus.id_instr[5:0];
  assign id_rs  = bus.id_instr[25:21];
  assign id_rt  = bus.id_instr[20:16];

  // Extend-select and operand-usage decode; unknown opcodes fall to sign extend
  logic [1:0] extop_c;
  logic       reads_rt_c, memread_c;
  always_comb begin
    extop_c    = 2'b00;
    reads_rt_c = 1'b0;
    memread_c  = 1'b0;
    case (opcode)
      6'h0C, 6'h0D, 6'h0E, 6'h0F: extop_c = 2'b01;
      6'h00: begin
        reads_rt_c = 1'b1;
        if (funct == 6'h00 || funct == 6'h02 || funct == 6'h03) extop_c = 2'b10;
      end
      6'h2B, 6'h04, 6'h05: reads_rt_c = 1'b1;
      6'h23: memread_c = 1'b1;
      default: ;
    endcase
  end

  // Load-use hazard: a valid load in EX whose nonzero destination feeds ID
  logic adv_c, hazard_c;
  assign adv_c    = ~ex_q.valid | bus.ex_ready;
  assign hazard_c = bus.id_valid & ex_q.valid & ex_q.memread & (ex_q.rt != '0) &
                    ((ex_q.rt == id_rs) | (reads_rt_c & (ex_q.rt == id_rt)));

  // Flush always consumes the ID word, even while EX is blocked
  assign bus.id_ready = bus.id_valid & (bus.flush | (adv_c & ~hazard_c));

  // EX entry next-value and control state
  always_comb begin
    ex_d    = ex_q;
    state_d = ST_ISSUE;
    if (adv_c) begin
      if (bus.flush || hazard_c) begin
        ex_d = '0;
      end else begin
        ex_d.valid   = bus.id_valid;
        ex_d.extop   = extop_c;
        ex_d.imm16   = bus.id_instr[15:0];
        ex_d.shamt   = bus.id_instr[10:6];
        ex_d.rs      = id_rs;
        ex_d.rt      = id_rt;
        ex_d.memread = memread_c;
      end
    end
    if (ex_q.valid && !bus.ex_ready) state_d = ST_BP_STALL;
    else if (hazard_c && !bus.flush) state_d = ST_LU_STALL;
  end

  // EX register and FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= '0;
      state_q <= ST_ISSUE;
    end else begin
      ex_q    <= ex_d;
      state_q <= state_d;
    end
  end

  assign bus.ex_valid   = ex_q.valid;
  assign bus.ex_extop   = ex_q.extop;
  assign bus.ex_imm16   = ex_q.imm16;
  assign bus.ex_shamt   = ex_q.shamt;
  assign bus.ex_rs      = ex_q.rs;
  assign bus.ex_rt      = ex_q.rt;
  assign bus.ex_memread = ex_q.memread;
  assign bus.ctrl_state = state_q;

`ifdef DECODE_STALL_CNT_EN
  localparam int unsigned CNT_W = 16;

  // Counts only bubbles inserted for load-use; saturates instead of wrapping
  logic             lu_bubble_c;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  assign lu_bubble_c = adv_c & hazard_c & ~bus.flush;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (lu_bubble_c && stall_cnt_q != '1) stall_cnt_d = CNT_W'(stall_cnt_q + CNT_W'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign bus.stall_cnt = stall_cnt_q;
`else
  assign bus.stall_cnt = '0;
`endif

endmodule

// File: tb/tb_decode_ctrl.sv
module tb_decode_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  logic [15:0] exp_cnt;

`ifdef DECODE_STALL_CNT_EN
  localparam logic [15:0] CNT_STEP = 16'd1;
`else
  localparam logic [15:0] CNT_STEP = 16'd0;
`endif

  decode_ctrl_if bus ();
  decode_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  // {valid, memread, extop, imm16, shamt, rs, rt}
  function automatic logic [34:0] ex_bits();
    return {bus.ex_valid, bus.ex_memread, bus.ex_extop, bus.ex_imm16,
            bus.ex_shamt, bus.ex_rs, bus.ex_rt};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic fl, input logic er);
    bus.id_valid = v;
    bus.id_instr = ins;
    bus.flush    = fl;
    bus.ex_ready = er;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    #1;
    checks++;
    if ({ex_bits(), bus.ctrl_state, bus.stall_cnt} !== 53'd0) begin
      $display("FAIL reset_state: got %h want 0", {ex_bits(), bus.ctrl_state, bus.stall_cnt}); errors++;
    end
    checks++;
    if (bus.id_ready !== 1'b0) begin
      $display("FAIL reset_id_ready: got %b want 0", bus.id_ready); errors++;
    end
    #2;
    rst_n = 1'b1;
    exp_cnt = 16'd0;
    tick();
  endtask

  task automatic test_decode();
    logic [31:0] ins [7];
    logic [34:0] exp [7];
    ins[0] = itype(6'h0D, 5'd1, 5'd3, 16'h1234);  exp[0] = {1'b1, 1'b0, 2'b01, 16'h1234, 5'd8,  5'd1, 5'd3};
    ins[1] = rtype(5'd0, 5'd4, 5'd2, 5'd5, 6'h00); exp[1] = {1'b1, 1'b0, 2'b10, 16'h1140, 5'd5,  5'd0, 5'd4};
    ins[2] = itype(6'h23, 5'd9, 5'd8, 16'h0010);  exp[2] = {1'b1, 1'b1, 2'b00, 16'h0010, 5'd0,  5'd9, 5'd8};
    ins[3] = itype(6'h0C, 5'd1, 5'd2, 16'hFFC0);  exp[3] = {1'b1, 1'b0, 2'b01, 16'hFFC0, 5'd31, 5'd1, 5'd2};
    ins[4] = itype(6'h3F, 5'd3, 5'd4, 16'h0041);  exp[4] = {1'b1, 1'b0, 2'b00, 16'h0041, 5'd1,  5'd3, 5'd4};
    ins[5] = rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20); exp[5] = {1'b1, 1'b0, 2'b00, 16'h1820, 5'd0,  5'd1, 5'd2};
    ins[6] = rtype(5'd0, 5'd6, 5'd7, 5'd31, 6'h02); exp[6] = {1'b1, 1'b0, 2'b10, 16'h3FC2, 5'd31, 5'd0, 5'd6};
    idle();
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, ins[i], 1'b0, 1'b1);
      checks++;
      if (bus.id_ready !== 1'b1) begin
        $display("FAIL decode_id_ready[%0d]: got %b want 1", i, bus.id_ready); errors++;
      end
      tick();
      checks++;
      if (ex_bits() !== exp[i]) begin
        $display("FAIL decode_entry[%0d]: got %h want %h", i, ex_bits(), exp[i]); errors++;
      end
    end
    idle();
  endtask

  task automatic test_load_use();
    logic [31:0] lw5, add;
    lw5 = itype(6'h23, 5'd1, 5'd5, 16'h0004);
    add = rtype(5'd5, 5'd7, 5'd6, 5'd0, 6'h20);
    idle();
    drive(1'b1, lw5, 1'b0, 1'b1);
    tick();
    drive(1'b1, add, 1'b0, 1'b1);
    checks++;
    if (bus.id_ready !== 1'b0) begin
      $display("FAIL lu_id_ready_hazard: got %b want 0", bus.id_ready); errors++;
    end
    tick();
    exp_cnt = exp_cnt + CNT_STEP;
    checks++;
    if (ex_bits() !== 35'd0) begin
      $display("FAIL lu_bubble: got %h want 0", ex_bits()); errors++;
    end
    checks++;
    if (bus.ctrl_state !== 2'b01) begin
      $display("FAIL lu_state: got %b want 01", bus.ctrl_state); errors++;
    end
    checks++;
    if (bus.stall_cnt !== exp_cnt) begin
      $display("FAIL lu_stall_cnt: got %0d want %0d", bus.stall_cnt, exp_cnt); errors++;
    end
    checks++;
    if (bus.id_ready !== 1'b1) begin
      $display("FAIL lu_id_ready_release: got %b want 1", bus.id_ready); errors++;
    end
    tick();
    checks++;
    if (ex_bits() !== {1'b1, 1'b0, 2'b00, 16'h3020, 5'd0, 5'd5, 5'd7}) begin
      $display("FAIL lu_dependent_issue: got %h want %h", ex_bits(), {1'b1, 1'b0, 2'b00, 16'h3020, 5'd0, 5'd5, 5'd7}); errors++;
    end
    checks++;
    if (bus.ctrl_state !== 2'b00) begin
      $display("FAIL lu_state_after: got %b want 00", bus.ctrl_state); errors++;
    end
    idle();
  endtask

  task automatic test_r0();
    idle();
    drive(1'b1, itype(6'h23, 5'd2, 5'd0, 16'h0008), 1'b0, 1'b1);
    tick();
    drive(1'b1, rtype(5'd0, 5'd0, 5'd1, 5'd0, 6'h20), 1'b0, 1'b1);
    checks++;
    if (bus.id_ready !== 1'b1) begin
      $display("FAIL r0_no_hazard: got %b want 1", bus.id_ready); errors++;
    end
    tick();
    checks++;
    if ({bus.ex_valid, bus.ctrl_state} !== 3'b100) begin
      $display("FAIL r0_issue: got %b want 100", {bus.ex_valid, bus.ctrl_state}); errors++;
    end
    drive(1'b1, itype(6'h23, 5'd3, 5'd5, 16'h0000), 1'b0, 1'b1);
    tick();
    drive(1'b1, itype(6'h2B, 5'd1, 5'd5, 16'h000C), 1'b0, 1'b1);
    checks++;
    if (bus.id_ready !== 1'b0) begin
      $display("FAIL sw_rt_hazard: got %b want 0", bus.id_ready); errors++;
    end
    tick();
    exp_cnt = exp_cnt + CNT_STEP;
    checks++;
    if ({bus.ex_valid, bus.ctrl_state} !== 3'b001) begin
      $display("FAIL sw_bubble: got %b want 001", {bus.ex_valid, bus.ctrl_state}); errors++;
    end
    tick();
    checks++;
    if (ex_bits() !== {1'b1, 1'b0, 2'b00, 16'h000C, 5'd0, 5'd1, 5'd5}) begin
      $display("FAIL sw_issue: got %h want %h", ex_bits(), {1'b1, 1'b0, 2'b00, 16'h000C, 5'd0, 5'd1, 5'd5}); errors++;
    end
    idle();
  endtask

  task automatic test_backpressure();
    logic [34:0] held;
    held = {1'b1, 1'b0, 2'b00, 16'h000C, 5'd0, 5'd1, 5'd5};
    idle();
    drive(1'b1, itype(6'h2B, 5'd1, 5'd5, 16'h000C), 1'b0, 1'b1);
    tick();
    drive(1'b1, itype(6'h0D, 5'd2, 5'd3, 16'h00FF), 1'b0, 1'b0);
    checks++;
    if ({bus.id_ready, bus.ctrl_state} !== 3'b000) begin
      $display("FAIL bp_first_cycle: got %b want 000", {bus.id_ready, bus.ctrl_state}); errors++;
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (ex_bits() !== held) begin
        $display("FAIL bp_hold[%0d]: got %h want %h", i, ex_bits(), held); errors++;
      end
      checks++;
      if ({bus.id_ready, bus.ctrl_state} !== 3'b010) begin
        $display("FAIL bp_state[%0d]: got %b want 010", i, {bus.id_ready, bus.ctrl_state}); errors++;
      end
    end
    drive(1'b1, itype(6'h0D, 5'd2, 5'd3, 16'h00FF), 1'b0, 1'b1);
    tick();
    checks++;
    if ({ex_bits(), bus.ctrl_state} !== {1'b1, 1'b0, 2'b01, 16'h00FF, 5'd3, 5'd2, 5'd3, 2'b00}) begin
      $display("FAIL bp_release: got %h want %h", {ex_bits(), bus.ctrl_state}, {1'b1, 1'b0, 2'b01, 16'h00FF, 5'd3, 5'd2, 5'd3, 2'b00}); errors++;
    end
    idle();
  endtask

  task automatic test_flush();
    logic [31:0] lw5, add;
    lw5 = itype(6'h23, 5'd1, 5'd5, 16'h0004);
    add = rtype(5'd5, 5'd7, 5'd6, 5'd0, 6'h20);
    idle();
    drive(1'b1, lw5, 1'b0, 1'b1);
    tick();
    drive(1'b1, add, 1'b1, 1'b1);
    checks++;
    if (bus.id_ready !== 1'b1) begin
      $display("FAIL flush_id_ready: got %b want 1", bus.id_ready); errors++;
    end
    tick();
    checks++;
    if ({ex_bits(), bus.ctrl_state} !== 37'd0) begin
      $display("FAIL flush_bubble: got %h want 0", {ex_bits(), bus.ctrl_state}); errors++;
    end
    checks++;
    if (bus.stall_cnt !== exp_cnt) begin
      $display("FAIL flush_stall_cnt: got %0d want %0d", bus.stall_cnt, exp_cnt); errors++;
    end
    drive(1'b1, lw5, 1'b0, 1'b1);
    tick();
    drive(1'b1, add, 1'b1, 1'b0);
    checks++;
    if (bus.id_ready !== 1'b1) begin
      $display("FAIL flush_blocked_id_ready: got %b want 1", bus.id_ready); errors++;
    end
    tick();
    checks++;
    if ({ex_bits(), bus.ctrl_state} !== {1'b1, 1'b1, 2'b00, 16'h0004, 5'd0, 5'd1, 5'd5, 2'b10}) begin
      $display("FAIL flush_blocked_hold: got %h want %h", {ex_bits(), bus.ctrl_state}, {1'b1, 1'b1, 2'b00, 16'h0004, 5'd0, 5'd1, 5'd5, 2'b10}); errors++;
    end
    idle();
  endtask

  task automatic test_reset_mid_stall();
    logic [31:0] lw5, add;
    lw5 = itype(6'h23, 5'd1, 5'd5, 16'h0004);
    add = rtype(5'd5, 5'd7, 5'd6, 5'd0, 6'h20);
    idle();
    drive(1'b1, lw5, 1'b0, 1'b1);
    tick();
    drive(1'b1, add, 1'b0, 1'b1);
    tick();
    checks++;
    if (bus.ctrl_state !== 2'b01) begin
      $display("FAIL rst_mid_pre_state: got %b want 01", bus.ctrl_state); errors++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ex_bits(), bus.ctrl_state, bus.stall_cnt} !== 53'd0) begin
      $display("FAIL rst_mid_async_clear: got %h want 0", {ex_bits(), bus.ctrl_state, bus.stall_cnt}); errors++;
    end
    exp_cnt = 16'd0;
    #1;
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.id_ready !== 1'b1) begin
      $display("FAIL rst_mid_empty_ex: got %b want 1", bus.id_ready); errors++;
    end
    tick();
    checks++;
    if (ex_bits() !== {1'b1, 1'b0, 2'b00, 16'h3020, 5'd0, 5'd5, 5'd7}) begin
      $display("FAIL rst_mid_first_issue: got %h want %h", ex_bits(), {1'b1, 1'b0, 2'b00, 16'h3020, 5'd0, 5'd5, 5'd7}); errors++;
    end
    checks++;
    if (bus.stall_cnt !== exp_cnt) begin
      $display("FAIL rst_mid_stall_cnt: got %0d want %0d", bus.stall_cnt, exp_cnt); errors++;
    end
    idle();
  endtask

`ifdef DECODE_STALL_CNT_EN
  task automatic test_saturate();
    idle();
    force dut.stall_cnt_q = 16'hFFFF;
    #1;
    release dut.stall_cnt_q;
    drive(1'b1, itype(6'h23, 5'd1, 5'd5, 16'h0004), 1'b0, 1'b1);
    tick();
    drive(1'b1, rtype(5'd5, 5'd7, 5'd6, 5'd0, 6'h20), 1'b0, 1'b1);
    tick();
    checks++;
    if ({bus.ex_valid, bus.stall_cnt} !== {1'b0, 16'hFFFF}) begin
      $display("FAIL stall_cnt_saturate: got %h want %h", {bus.ex_valid, bus.stall_cnt}, {1'b0, 16'hFFFF}); errors++;
    end
    idle();
  endtask
`endif

  initial begin
    test_reset();
    test_decode();
    test_load_use();
    test_r0();
    test_backpressure();
    test_flush();
    test_reset_mid_stall();
`ifdef DECODE_STALL_CNT_EN
    test_saturate();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decode_ctrl.md
DECODE_CTRL -- requirements
Module: decode_ctrl

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst_n  in  1  asynchronous active-low reset.
REQ-003 id_valid  in  1  ID-stage instruction present.
REQ-004 id_instr  in  32  ID-stage instruction word.
REQ-005 id_ready  out  1  ID instruction consumed this cycle.
REQ-006 flush  in  1  kill ID instruction (branch taken).
REQ-007 ex_ready  in  1  EX stage accepts the held entry.
REQ-008 ex_valid  out  1  EX entry valid.
REQ-009 ex_extop  out  2  extend-unit select: 00 sign, 01 zero, 10 shamt.
REQ-010 ex_imm16  out  16  id_instr[15:0] registered.
REQ-011 ex_shamt  out  5  id_instr[10:6] registered.
REQ-012 ex_rs, ex_rt  out  5 each  register fields registered.
REQ-013 ex_memread  out  1  EX entry is lw.
REQ-014 ctrl_state  out  2  00 ISSUE, 01 LU_STALL, 10 BP_STALL; 11 never output.
REQ-015 stall_cnt  out  16  load-use bubble count (see Configuration).

Function
REQ-016 Decode, sign (00): opcode 08,09,0A,0B,23,2B,04,05 (hex) and every undefined opcode.
REQ-017 Decode, zero (01): opcode 0C,0D,0E,0F.
REQ-018 Decode, shamt (10): opcode 00 with funct 00,02,03; other opcode-00 encodings decode 00.
REQ-019 reads_rt = opcode 00, 2B, 04 or 05; memread = opcode 23.
REQ-020 adv = ~ex_valid | ex_ready.
REQ-021 hazard = id_valid & ex_valid & ex_memread & (ex_rt != 0) & (ex_rt == rs | (reads_rt & ex_rt == rt)).
REQ-022 id_ready = flush | (adv & ~hazard); combinational, asserted only if id_valid.
REQ-023 On adv with flush: EX register loads bubble (ex_valid=0, ex_memread=0); ID instruction discarded.
REQ-024 On adv with hazard and no flush: EX register loads bubble; ID instruction held.
REQ-025 On adv, no flush, no hazard: ex_valid<=id_valid; fields load from id_instr and decode.
REQ-026 Without adv: all EX fields hold; flush still discards the ID instruction.
REQ-027 Bubble entries load zero into ex_extop, ex_imm16, ex_shamt, ex_rs, ex_rt.
REQ-028 Load-use penalty exactly one bubble cycle; the dependent instruction issues on the following adv.
REQ-029 FSM next state: BP_STALL if ex_valid & ~ex_ready; else LU_STALL if hazard & ~flush; else ISSUE.
REQ-030 ctrl_state is the registered FSM state; it reflects the previous cycle's condition.

Reset
REQ-031 rst_n low asynchronously clears every EX field, ex_valid, stall_cnt to 0 and ctrl_state to ISSUE.
REQ-032 Reset mid-stall drops the bubble and held entry; first cycle after release behaves as empty EX.

Configuration
REQ-033 Macro DECODE_STALL_CNT_EN defined: stall_cnt increments by 1 per cycle in which REQ-024 loads a bubble; saturates at 16'hFFFF; no wrap.
REQ-034 Macro undefined: stall_cnt constant 0, no counter logic; all other behaviour identical.

Verification
REQ-035 lw $5 issued, next ID add $6,$5,$7, ex_ready=1 -> one bubble (ex_valid=0, ctrl_state 01), add issues next cycle, stall_cnt=1 (macro on).
REQ-036 ori (opcode 0D), then sll (funct 00), then lw -> ex_extop 01, 10, 00 on consecutive cycles; ex_imm16 and ex_shamt match instruction bits.
REQ-037 ex_valid=1, ex_ready=0 for 3 cycles with id_valid=1 -> id_ready=0, EX fields stable, ctrl_state 10 from second cycle.
REQ-038 lw $0 followed by use of $0 -> no bubble; lw $5 then sw with rt=5 -> one bubble.
REQ-039 flush=1 during a load-use hazard -> id_ready=1, bubble loaded, stall_cnt unchanged, ctrl_state 00.
REQ-040 rst_n asserted mid-LU_STALL asynchronously -> all outputs 0 before next edge; stall_cnt preset 16'hFFFF plus extra hazard holds at 16'hFFFF.
